// File: rtl/core_status_reg.sv
// core_status_reg
// Processor status (P) register and interrupt-poll stage sitting directly
// after the ALU. Holds C/Z/V/N/D/I, returns C/V/N/Z to the ALU, applies
// flag set/clear micro-ops and P loads from the data bus, builds the pushed
// status byte, and decides at each instruction poll whether an NMI
// (edge-detected, latched) or IRQ (level, masked by I) is taken.
//
// Ports
//   I_clock, I_reset_n           clock, synchronous active-low reset
//   I_ready                      stage enable (0 = hold flags/pending/is_nmi)
//   I_alu_*                      ALU flag results, captured on I_alu_write
//   I_flag_write/sel/value       single-flag micro-op (sel 0=C 1=I 2=V 3=D)
//   I_bus_data, I_load_bus       P load from data bus (PLP/RTI)
//   I_push_brk                   B bit driven into O_status
//   I_nmi_n, I_irq_n             external interrupt lines, active low
//   I_poll, I_int_ack            poll point / interrupt sequence commit
//   O_carry..O_decimal           current flags
//   O_status                     {N,V,1,B,D,I,Z,C}
//   O_int_pending, O_int_is_nmi  interrupt decision awaiting ack
module core_status_reg #(
  parameter logic RESET_I  = 1'b1,
  parameter int   NMI_SYNC = 1
) (
  input  logic       I_clock,
  input  logic       I_reset_n,
  input  logic       I_ready,
  input  logic       I_alu_carry,
  input  logic       I_alu_overflow,
  input  logic       I_alu_sign,
  input  logic       I_alu_zero,
  input  logic       I_alu_write,
  input  logic       I_flag_write,
  input  logic [1:0] I_flag_sel,
  input  logic       I_flag_value,
  input  logic [7:0] I_bus_data,
  input  logic       I_load_bus,
  input  logic       I_push_brk,
  input  logic       I_nmi_n,
  input  logic       I_irq_n,
  input  logic       I_poll,
  input  logic       I_int_ack,
  output logic       O_carry,
  output logic       O_overflow,
  output logic       O_sign,
  output logic       O_zero,
  output logic       O_irq_disable,
  output logic       O_decimal,
  output logic [7:0] O_status,
  output logic       O_int_pending,
  output logic       O_int_is_nmi
);

  logic flag_c, flag_z, flag_v, flag_n, flag_d, flag_i;
  logic c_next, z_next, v_next, n_next, d_next, i_next;

  logic nmi_sync, irq_sync, nmi_prev, nmi_latch;
  logic int_pending, int_is_nmi;
  logic nmi_line, irq_line, nmi_fall, irq_asserted, nmi_clear;

  // With NMI_SYNC == 0 the raw pins feed detection directly.
  assign nmi_line     = (NMI_SYNC != 0) ? nmi_sync : I_nmi_n;
  assign irq_line     = (NMI_SYNC != 0) ? irq_sync : I_irq_n;
  assign nmi_fall     = nmi_prev & ~nmi_line;
  assign irq_asserted = ~irq_line;
  // Only an ack of an NMI consumes the latch; an IRQ ack leaves it alone.
  assign nmi_clear    = I_ready & I_int_ack & int_is_nmi;

  // Later assignments override earlier ones: ALU < flag micro-op < bus load
  // < ack forcing I.
  always_comb begin
    c_next = flag_c;
    z_next = flag_z;
    v_next = flag_v;
    n_next = flag_n;
    d_next = flag_d;
    i_next = flag_i;
    if (I_alu_write) begin
      c_next = I_alu_carry;
      z_next = I_alu_zero;
      v_next = I_alu_overflow;
      n_next = I_alu_sign;
    end
    if (I_flag_write) begin
      case (I_flag_sel)
        2'd0:    c_next = I_flag_value;
        2'd1:    i_next = I_flag_value;
        2'd2:    v_next = I_flag_value;
        default: d_next = I_flag_value;
      endcase
    end
    if (I_load_bus) begin
      n_next = I_bus_data[7];
      v_next = I_bus_data[6];
      d_next = I_bus_data[3];
      i_next = I_bus_data[2];
      z_next = I_bus_data[1];
      c_next = I_bus_data[0];
    end
    if (I_int_ack) begin
      i_next = 1'b1;
    end
  end

  always_ff @(posedge I_clock) begin
    if (!I_reset_n) begin
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_v      <= 1'b0;
      flag_n      <= 1'b0;
      flag_d      <= 1'b0;
      flag_i      <= RESET_I;
      nmi_sync    <= 1'b1;
      irq_sync    <= 1'b1;
      nmi_prev    <= 1'b1;
      nmi_latch   <= 1'b0;
      int_pending <= 1'b0;
      int_is_nmi  <= 1'b0;
    end else begin
      // Edge detection runs regardless of I_ready so NMIs are never lost.
      nmi_sync  <= I_nmi_n;
      irq_sync  <= I_irq_n;
      nmi_prev  <= nmi_line;
      nmi_latch <= nmi_fall | (nmi_latch & ~nmi_clear);

      if (I_ready) begin
        flag_c <= c_next;
        flag_z <= z_next;
        flag_v <= v_next;
        flag_n <= n_next;
        flag_d <= d_next;
        flag_i <= i_next;

        if (I_int_ack) begin
          int_pending <= 1'b0;
          int_is_nmi  <= 1'b0;
        end else if (int_pending) begin
          // NMI arriving while an IRQ waits for ack hijacks the sequence.
          if (nmi_latch) begin
            int_is_nmi <= 1'b1;
          end
        end else if (I_poll) begin
          // Masked by the I value before this edge, so CLI/SEI on the poll
          // cycle only affects the following instruction.
          int_pending <= nmi_latch | (irq_asserted & ~flag_i);
          int_is_nmi  <= nmi_latch;
        end
      end
    end
  end

  assign O_carry       = flag_c;
  assign O_overflow    = flag_v;
  assign O_sign        = flag_n;
  assign O_zero        = flag_z;
  assign O_irq_disable = flag_i;
  assign O_decimal     = flag_d;
  assign O_status      = {flag_n, flag_v, 1'b1, I_push_brk, flag_d, flag_i, flag_z, flag_c};
  assign O_int_pending = int_pending;
  assign O_int_is_nmi  = int_is_nmi;

endmodule
